// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU core and anything else that
// reuses the combinational ALU.
//   - opcode constants (6-bit encodings)
//   - button index assignments
//   - flag bit indices inside the {carry, overflow, zero} vector
//   - FSM state encoding of the sequencer
package alu_pkg;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;

  localparam int BTN_A     = 0;
  localparam int BTN_B     = 1;
  localparam int BTN_OP    = 2;
  localparam int BTN_CHAIN = 3;

  localparam int NB_FLAGS   = 3;
  localparam int FLAG_CARRY = 2;
  localparam int FLAG_OVF   = 1;
  localparam int FLAG_ZERO  = 0;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_EXEC = 2'd1,
    ST_SHOW = 2'd2
  } state_t;

endpackage

// File: rtl/alu_seq_core_if.sv
// Board-side bundle of the sequential ALU core.
//   i_sw    : switch data (operands, opcode in the low bits)
//   i_btn   : raw asynchronous buttons {chain, load OP, load B, load A}
//   o_led   : registered ALU result
//   o_flags : registered {carry, overflow, zero}
//   o_valid : A, B and OP have all been loaded since reset
// master = stimulus side, slave = the core.
interface alu_seq_core_if #(
  parameter int NB_DATA = 8,
  parameter int NB_BTN  = 4
);
  logic [NB_DATA-1:0] i_sw;
  logic [NB_BTN-1:0]  i_btn;
  logic [NB_DATA-1:0] o_led;
  logic [2:0]         o_flags;
  logic               o_valid;

  modport master (output i_sw, i_btn, input o_led, o_flags, o_valid);
  modport slave  (input i_sw, i_btn, output o_led, o_flags, o_valid);
endinterface

// File: rtl/alu_comb.sv
// Purely combinational ALU.
//   a, b   : operands (unsigned bit vectors, signed view for overflow/SRA)
//   op     : opcode, compared against the encodings in alu_pkg
//   result : a op b
//   flags  : {carry, overflow, zero}; undefined opcodes give 0 with zero set
module alu_comb
  import alu_pkg::*;
#(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic [NB_DATA-1:0]  a,
  input  logic [NB_DATA-1:0]  b,
  input  logic [NB_OP-1:0]    op,
  output logic [NB_DATA-1:0]  result,
  output logic [NB_FLAGS-1:0] flags
);

  localparam int M = NB_DATA - 1;
  localparam logic [NB_DATA-1:0] WIDTH_V = NB_DATA'(NB_DATA);

  logic [NB_DATA:0] sum, diff;
  logic             carry, ovf, over_shift;

  always_comb begin
    sum        = {1'b0, a} + {1'b0, b};
    diff       = {1'b0, a} - {1'b0, b};
    // Shift amounts of NB_DATA or more saturate instead of wrapping.
    over_shift = (b >= WIDTH_V);
    result     = '0;
    carry      = 1'b0;
    ovf        = 1'b0;
    case (op)
      NB_OP'(OP_ADD): begin
        result = sum[M:0];
        carry  = sum[NB_DATA];
        ovf    = (a[M] == b[M]) && (result[M] != a[M]);
      end
      NB_OP'(OP_SUB): begin
        result = diff[M:0];
        // No borrow out of the top bit means a >= b unsigned.
        carry  = ~diff[NB_DATA];
        ovf    = (a[M] != b[M]) && (result[M] != a[M]);
      end
      NB_OP'(OP_AND): result = a & b;
      NB_OP'(OP_OR):  result = a | b;
      NB_OP'(OP_XOR): result = a ^ b;
      NB_OP'(OP_NOR): result = ~(a | b);
      NB_OP'(OP_SRA): result = over_shift ? {NB_DATA{a[M]}} : NB_DATA'($signed(a) >>> b);
      NB_OP'(OP_SRL): result = over_shift ? '0 : (a >> b);
      default:        result = '0;
    endcase
    flags             = '0;
    flags[FLAG_CARRY] = carry;
    flags[FLAG_OVF]   = ovf;
    flags[FLAG_ZERO]  = (result == '0);
  end

endmodule

// File: rtl/alu_seq_core.sv
// Button-driven sequential ALU.
//   clock   : system clock, rising edge
//   i_reset : synchronous active-high reset
//   bus     : alu_seq_core_if.slave (switches, buttons, LEDs, flags, valid)
// Each button is synchronised (2 flops) and edge-detected against a history
// flop; the resulting one-cycle pulses load A, B, OP or chain the result
// back into A. A small FSM registers the ALU output one cycle after a load
// once all three registers hold data.
module alu_seq_core
  import alu_pkg::*;
#(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6,
  parameter int NB_BTN  = 4
) (
  input logic           clock,
  input logic           i_reset,
  alu_seq_core_if.slave bus
);

  logic [NB_BTN-1:0]   pulse;
  logic [2:0]          settle;
  logic [NB_DATA-1:0]  a, b, led, alu_res;
  logic [NB_OP-1:0]    op;
  logic [NB_FLAGS-1:0] flags, alu_flags;
  logic                ld_a, ld_b, ld_op, valid;
  logic                ld_a_nxt, ld_b_nxt, ld_op_nxt, all_nxt, load_any;
  state_t              state;

  // settle[2] rises once the history flops hold genuinely sampled levels
  // after reset; until then a button held across reset would look like a
  // fresh edge, so edges are masked.
  for (genvar n = 0; n < NB_BTN; n++) begin : g_btn
    logic s1, s2, h;
    always_ff @(posedge clock) begin
      if (i_reset) begin
        s1 <= 1'b0;
        s2 <= 1'b0;
        h  <= 1'b0;
      end else begin
        s1 <= bus.i_btn[n];
        s2 <= s1;
        h  <= s2;
      end
    end
    assign pulse[n] = s2 & ~h & settle[2];
  end

  always_comb begin
    ld_a_nxt  = ld_a | pulse[BTN_A] | pulse[BTN_CHAIN];
    ld_b_nxt  = ld_b | pulse[BTN_B];
    ld_op_nxt = ld_op | pulse[BTN_OP];
    all_nxt   = ld_a_nxt & ld_b_nxt & ld_op_nxt;
    load_any  = |pulse;
  end

  alu_comb #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) u_alu (
    .a      (a),
    .b      (b),
    .op     (op),
    .result (alu_res),
    .flags  (alu_flags)
  );

  always_ff @(posedge clock) begin
    if (i_reset) begin
      settle <= '0;
      a      <= '0;
      b      <= '0;
      op     <= '0;
      ld_a   <= 1'b0;
      ld_b   <= 1'b0;
      ld_op  <= 1'b0;
      led    <= '0;
      flags  <= '0;
      valid  <= 1'b0;
      state  <= ST_WAIT;
    end else begin
      settle <= {settle[1:0], 1'b1};
      // Direct load beats chain when both land together.
      if (pulse[BTN_A])          a <= bus.i_sw;
      else if (pulse[BTN_CHAIN]) a <= led;
      if (pulse[BTN_B])  b  <= bus.i_sw;
      if (pulse[BTN_OP]) op <= bus.i_sw[NB_OP-1:0];
      ld_a  <= ld_a_nxt;
      ld_b  <= ld_b_nxt;
      ld_op <= ld_op_nxt;
      case (state)
        ST_WAIT: if (load_any && all_nxt) begin
          state <= ST_EXEC;
          valid <= 1'b1;
        end
        // Operands were updated on the edge that entered EXEC.
        ST_EXEC: begin
          led   <= alu_res;
          flags <= alu_flags;
          state <= ST_SHOW;
        end
        ST_SHOW: if (load_any) state <= ST_EXEC;
        default: state <= ST_WAIT;
      endcase
    end
  end

  assign bus.o_led   = led;
  assign bus.o_flags = flags;
  assign bus.o_valid = valid;

endmodule

// File: tb/tb_alu_seq_core.sv
module tb_alu_seq_core;

  logic clock = 1'b0;
  logic i_reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  alu_seq_core_if #(.NB_DATA(8), .NB_BTN(4)) bus ();

  alu_seq_core #(.NB_DATA(8), .NB_OP(6), .NB_BTN(4)) dut (
    .clock   (clock),
    .i_reset (i_reset),
    .bus     (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [7:0] led;
    logic [2:0] flags;
    logic       valid;
  } exp_t;
  exp_t q[$];

  // Reference state: operands as plain integers.
  int         ma, mb, mop;
  bit         la, lb, lop;
  logic [7:0] m_led;
  logic [2:0] m_flags;
  logic       m_valid;
  logic [3:0] stuck;

  function automatic void ref_alu(input int a, input int b, input int op,
                                  output int res, output bit c, output bit v);
    int sa, sb, t;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    res = 0; c = 0; v = 0;
    case (op)
      'h20: begin t = a + b; res = t % 256; c = (t > 255); t = sa + sb; v = (t > 127) || (t < -128); end
      'h22: begin res = (a - b + 256) % 256; c = (a >= b); t = sa - sb; v = (t > 127) || (t < -128); end
      'h24: res = a & b;
      'h25: res = a | b;
      'h26: res = a ^ b;
      'h27: res = 255 - (a | b);
      'h03: res = (b >= 8) ? ((sa < 0) ? 255 : 0) : ((sa >>> b) & 255);
      'h02: res = (b >= 8) ? 0 : a / (1 << b);
      default: res = 0;
    endcase
  endfunction

  task automatic model_reset();
    ma = 0; mb = 0; mop = 0; la = 0; lb = 0; lop = 0;
    m_led = '0; m_flags = '0; m_valid = 1'b0;
  endtask

  task automatic apply_model(input logic [3:0] eff, input logic [7:0] sw);
    int r; bit c, v;
    if (eff[0])      ma = int'(sw);
    else if (eff[3]) ma = int'(m_led);
    if (eff[1]) mb  = int'(sw);
    if (eff[2]) mop = int'(sw[5:0]);
    la  = la | eff[0] | eff[3];
    lb  = lb | eff[1];
    lop = lop | eff[2];
    if (eff != 0 && la && lb && lop) begin
      ref_alu(ma, mb, mop, r, c, v);
      m_led   = 8'(r);
      m_flags = {c, v, (r == 0)};
      m_valid = 1'b1;
    end
  endtask

  task automatic expect_at(input int at);
    exp_t e;
    e.at = at; e.led = m_led; e.flags = m_flags; e.valid = m_valid;
    q.push_back(e);
  endtask

  // Press a button mask for 'hold' cycles; sw switches to sw_late after
  // five cycles so any extra load during a long hold becomes visible.
  task automatic press(input logic [3:0] mask, input logic [7:0] sw,
                       input int hold, input logic [7:0] sw_late);
    @(negedge clock);
    bus.i_sw  = sw;
    bus.i_btn = mask;
    apply_model(mask & ~stuck, sw);
    expect_at(cyc + 4);
    for (int i = 0; i < hold; i++) begin
      if (i == 5) bus.i_sw = sw_late;
      @(negedge clock);
    end
    bus.i_btn = '0;
    stuck = '0;
    repeat (8) @(negedge clock);
    expect_at(cyc + 1);
  endtask

  task automatic p(input logic [3:0] mask, input logic [7:0] sw);
    press(mask, sw, 4, sw);
  endtask

  task automatic do_reset();
    @(negedge clock);
    i_reset = 1'b1;
    repeat (2) @(negedge clock);
    i_reset = 1'b0;
    model_reset();
    stuck = bus.i_btn;
    expect_at(cyc + 1);
    repeat (6) @(negedge clock);
  endtask

  // Monitor: compares whenever the head entry's cycle is reached.
  always @(negedge clock) begin
    if (q.size() > 0) begin
      if (q[0].at == cyc) begin
        total++;
        if (bus.o_led !== q[0].led || bus.o_flags !== q[0].flags || bus.o_valid !== q[0].valid) begin
          bad++;
          $display("FAIL out@%0d: got led=%h flags=%b valid=%b, want led=%h flags=%b valid=%b",
                   cyc, bus.o_led, bus.o_flags, bus.o_valid, q[0].led, q[0].flags, q[0].valid);
        end
        void'(q.pop_front());
      end else if (q[0].at < cyc) begin
        total++;
        bad++;
        $display("FAIL missed check @%0d (now %0d)", q[0].at, cyc);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] mask;
    logic [7:0] sw;
    int ops[8] = '{'h20, 'h22, 'h24, 'h25, 'h26, 'h27, 'h03, 'h02};
    int n;
    i_reset = 1'b1;
    bus.i_sw = '0;
    bus.i_btn = '0;
    stuck = '0;
    model_reset();
    repeat (3) @(negedge clock);
    i_reset = 1'b0;
    expect_at(cyc + 1);
    repeat (4) @(negedge clock);

    // Basic ADD / SUB
    p(4'b0001, 8'h04); p(4'b0010, 8'h0F); p(4'b0100, 8'h20);
    p(4'b0100, 8'h22);
    // Signed overflow
    p(4'b0001, 8'h7F); p(4'b0010, 8'h01); p(4'b0100, 8'h20);
    // Shifts including shift amount past the width
    p(4'b0001, 8'h80); p(4'b0010, 8'h03); p(4'b0100, 8'h03);
    p(4'b0100, 8'h02); p(4'b0010, 8'h09);
    p(4'b0100, 8'h03); p(4'b0010, 8'h08);
    // Chain
    p(4'b0001, 8'h04); p(4'b0010, 8'h0F); p(4'b0100, 8'h20);
    p(4'b1000, 8'hAA); p(4'b0100, 8'h20);
    // Long hold: exactly one load of A
    press(4'b0001, 8'h30, 50, 8'h70);
    // Load and chain together: load wins
    p(4'b1001, 8'h55);
    // Logic ops and an undefined opcode
    p(4'b0100, 8'h24); p(4'b0100, 8'h27); p(4'b0100, 8'h3F);

    // Reset between B and OP loads
    do_reset();
    p(4'b0001, 8'h11); p(4'b0010, 8'h22);
    do_reset();
    p(4'b0100, 8'h20);

    // In-flight pulse discarded by reset, button held across reset
    do_reset();
    p(4'b0001, 8'h05); p(4'b0010, 8'h06);
    @(negedge clock);
    bus.i_sw = 8'h20;
    bus.i_btn = 4'b0100;
    do_reset();
    p(4'b0001, 8'h05); p(4'b0010, 8'h06);
    p(4'b0100, 8'h20);

    // Button held across reset only counts after release
    @(negedge clock);
    bus.i_btn = 4'b0001;
    bus.i_sw = 8'h77;
    do_reset();
    p(4'b0011, 8'h22);
    p(4'b0100, 8'h20);
    p(4'b0001, 8'h10);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      mask = 4'($urandom_range(1, 15));
      if (mask[2]) begin
        n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63)) : ops[$urandom_range(0, 7)];
        sw = 8'($urandom_range(0, 3) * 64 + n);
      end else begin
        sw = 8'($urandom_range(0, 255));
      end
      press(mask, sw, int'($urandom_range(3, 6)), sw);
    end

    n = 0;
    while (q.size() > 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq_core.md
ALU_SEQ_CORE -- requirements
Module: alu_seq_core

Interface
REQ-001 Parameter NB_DATA, default 8, operand/result width (>=4).
REQ-002 Parameter NB_OP, default 6, opcode width.
REQ-003 Parameter NB_BTN, default 4, button count (fixed at 4 in this generation).
REQ-004 clock  in  1  single system clock, all logic on rising edge.
REQ-005 i_reset  in  1  synchronous, active-high reset.
REQ-006 i_sw  in  NB_DATA  switch data; operand source; opcode taken from i_sw[NB_OP-1:0].
REQ-007 i_btn  in  NB_BTN  asynchronous raw buttons: [0] load A, [1] load B, [2] load OP, [3] chain (A <= result).
REQ-008 o_led  out  NB_DATA  registered ALU result.
REQ-009 o_flags  out  3  registered {carry, overflow, zero}.
REQ-010 o_valid  out  1  high once A, B, OP have all been loaded since reset.

Function
REQ-011 Each button SHALL pass a 2-flop synchroniser plus a history flop; pulse = sync2 & ~hist, one cycle wide per rising edge.
REQ-012 A button held high any number of cycles SHALL produce exactly one pulse.
REQ-013 If edge k is the first to sample i_btn[n] high, the target register SHALL update at edge k+2 and o_led/o_flags at edge k+3.
REQ-014 Loads: pulse0 -> A <= i_sw; pulse1 -> B <= i_sw; pulse2 -> OP <= i_sw[NB_OP-1:0]; pulse3 -> A <= o_led.
REQ-015 Simultaneous pulses SHALL all apply in the same cycle; pulse0 and pulse3 together -> pulse0 wins.
REQ-016 Per-register loaded bits SHALL track A, B, OP; pulse3 sets A-loaded.
REQ-017 FSM states: WAIT (not all loaded), EXEC (one cycle, result registered), SHOW (holding result).
REQ-018 WAIT -> EXEC when a load completes the loaded set; SHOW -> EXEC on any load; EXEC -> SHOW unconditionally; no other transitions.
REQ-019 In WAIT, o_led, o_flags SHALL hold 0; o_valid SHALL be 0; o_valid SHALL be 1 in EXEC and SHOW.
REQ-020 Opcodes: ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SRA 000011, SRL 000010.
REQ-021 Undefined opcode SHALL produce result 0, carry 0, overflow 0, zero 1.
REQ-022 ADD: carry = unsigned carry-out of bit NB_DATA-1; overflow = signed overflow.
REQ-023 SUB: result = A-B mod 2^NB_DATA; carry = 1 iff A >= B unsigned; overflow = signed overflow.
REQ-024 Logic and shift ops SHALL force carry=0, overflow=0.
REQ-025 SRA/SRL shift A by B unsigned; shift amount >= NB_DATA SHALL give all-sign-bits (SRA) or 0 (SRL).
REQ-026 zero SHALL be 1 iff registered result == 0, for every opcode.

Reset
REQ-027 i_reset SHALL clear A, B, OP, loaded bits, synchroniser/history flops, o_led, o_flags, o_valid; FSM -> WAIT.
REQ-028 Reset mid-operation SHALL discard in-flight pulses; a button still held after reset release SHALL not produce a pulse until released and pressed again.
REQ-029 i_reset has priority over every load in the same cycle.

Structure
REQ-030 Opcode constants, FSM state encodings and flag bit indices SHALL live in shared package alu_pkg.
REQ-031 Combinational ALU SHALL be sub-module alu_comb (parameter NB_DATA, NB_OP), reusable by other tops.
REQ-032 Synchroniser/edge detect SHALL be one generate loop over NB_BTN, no per-button duplication.

Verification (NB_DATA=8)
REQ-033 Load A=0x04, B=0x0F, OP=ADD -> o_led 0x13, flags {0,0,0}, o_valid 1 at edge k+3 of OP press.
REQ-034 Then OP=SUB -> o_led 0xF5, carry 0, overflow 0; A=0x7F, B=0x01, ADD -> 0x80, overflow 1.
REQ-035 A=0x80, B=0x03, SRA -> 0xF0; SRL -> 0x10; B=0x09, SRL -> 0x00, zero 1.
REQ-036 Result 0x13, press chain, then OP=ADD with B=0x0F -> o_led 0x22.
REQ-037 Hold btn0 for 50 cycles -> exactly one A load; btn0+btn3 same cycle -> A = i_sw.
REQ-038 Assert i_reset between B and OP loads -> o_valid 0, o_led 0; OP load alone keeps WAIT.
